// File: rtl/booth_sequencer.sv
// booth_sequencer: radix-2 Booth control and registers for an 8x8 signed multiply using an external 8-bit adder.
module booth_sequencer (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start,
  input  logic [7:0]  mcand,
  input  logic [7:0]  mplier,
  input  logic [7:0]  sum_in,
  output logic [7:0]  adder_x,
  output logic [7:0]  adder_y,
  output logic        adder_cin,
  output logic [15:0] product,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t      r_state, w_next;
  logic [7:0]  r_a, r_q, r_m;
  logic        r_q1;
  logic [2:0]  r_cnt;
  logic [15:0] r_product;
  logic        r_busy, r_done;
  logic        w_run, w_load, w_last, w_add, w_sub, w_op, w_ovf, w_t;
  logic [7:0]  w_s;
  logic [16:0] w_shift;
  assign w_run  = r_state == S_RUN;
  assign w_load = start & ~w_run;
  assign w_last = w_run & (r_cnt == 3'd7);
  assign w_sub  = w_run & r_q[0] & ~r_q1;
  assign w_add  = w_run & ~r_q[0] & r_q1;
  assign w_op   = w_add | w_sub;
  assign adder_x   = r_m ^ {8{w_sub}};
  assign adder_y   = r_a;
  assign adder_cin = w_sub;
  assign w_s   = w_op ? sum_in : r_a;
  // The true sign of A +/- M survives signed overflow (e.g. subtracting -128).
  assign w_ovf = w_op & (adder_y[7] == adder_x[7]) & (sum_in[7] != adder_y[7]);
  assign w_t   = w_s[7] ^ w_ovf;
  assign w_shift = {w_t, w_s, r_q};
  assign product = r_product;
  assign busy    = r_busy;
  assign done    = r_done;
  always_comb begin
    w_next = w_run ? (w_last ? S_DONE : S_RUN) : (start ? S_RUN : S_IDLE);
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_a       <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_q1      <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (w_load) begin
      r_a    <= '0;
      r_q    <= mplier;
      r_m    <= mcand;
      r_q1   <= 1'b0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (w_run) begin
      r_a    <= w_shift[16:9];
      r_q    <= w_shift[8:1];
      r_q1   <= w_shift[0];
      r_cnt  <= r_cnt + 3'd1;
      r_busy <= ~w_last;
      r_done <= w_last;
      if (w_last) r_product <= w_shift[16:1];
    end else begin
      r_done <= 1'b0;
    end
  end
endmodule
